// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler for the elevator state machine.
// Latches call buttons, picks targets, times the door dwell.
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS  = 10,
    parameter int          FLOOR_W     = 4,
    parameter logic [31:0] DWELL_COUNT = 32'd20000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SELECT,
        S_TRAVEL,
        S_DWELL
    } state_t;

    state_t state;

    logic [NUM_FLOORS-1:0] sync1, sync2, sync3;
    logic [NUM_FLOORS-1:0] req, cur_oh, clr, set_v;
    logic                  cur_ok, serve, req_cur;
    logic [FLOOR_W-1:0]    lo_ge, lo_gt, hi_le, hi_lt;
    logic                  f_lo_ge, f_lo_gt, f_hi_le, f_hi_lt;
    logic [FLOOR_W-1:0]    sel_tgt;
    logic                  sel_ok;
    logic [31:0]           cnt;

    // Synchronize buttons and keep the previous sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= call_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign req = sync2 & ~sync3;

    // Nearest pending floors on either side of the car
    always_comb begin
        cur_oh  = '0;
        lo_ge   = '0;
        lo_gt   = '0;
        hi_le   = '0;
        hi_lt   = '0;
        f_lo_ge = 1'b0;
        f_lo_gt = 1'b0;
        f_hi_le = 1'b0;
        f_hi_lt = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            cur_oh[i] = (current_floor == FLOOR_W'(i));
            if (pending[i] && FLOOR_W'(i) >= current_floor) begin
                lo_ge   = FLOOR_W'(i);
                f_lo_ge = 1'b1;
            end
            if (pending[i] && FLOOR_W'(i) > current_floor) begin
                lo_gt   = FLOOR_W'(i);
                f_lo_gt = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && FLOOR_W'(i) <= current_floor) begin
                hi_le   = FLOOR_W'(i);
                f_hi_le = 1'b1;
            end
            if (pending[i] && FLOOR_W'(i) < current_floor) begin
                hi_lt   = FLOOR_W'(i);
                f_hi_lt = 1'b1;
            end
        end
    end

    // SCAN choice plus stop/request bookkeeping
    always_comb begin
        sel_tgt = requested_floor;
        sel_ok  = 1'b0;
        if (dir_up) begin
            if (f_lo_ge) begin
                sel_tgt = lo_ge;
                sel_ok  = 1'b1;
            end else if (f_hi_lt) begin
                sel_tgt = hi_lt;
                sel_ok  = 1'b1;
            end
        end else begin
            if (f_hi_le) begin
                sel_tgt = hi_le;
                sel_ok  = 1'b1;
            end else if (f_lo_gt) begin
                sel_tgt = lo_gt;
                sel_ok  = 1'b1;
            end
        end
        cur_ok  = |cur_oh;
        serve   = (state == S_TRAVEL) && car_idle && cur_ok
                  && (current_floor == requested_floor);
        req_cur = |(req & cur_oh);
        clr     = serve ? cur_oh : '0;
        set_v   = req & ~clr
                  & ((state == S_DWELL) ? ~cur_oh : {NUM_FLOORS{1'b1}});
    end

    // Pending set: new requests in, served floor out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_v) & ~clr;
        end
    end

    // Scheduler FSM with registered target, direction, door and dwell timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_WAIT;
            requested_floor <= '0;
            dir_up          <= 1'b1;
            door_open       <= 1'b0;
            cnt             <= '0;
        end else begin
            unique case (state)
                S_WAIT: begin
                    requested_floor <= current_floor;
                    if (|pending) state <= S_SELECT;
                end
                S_SELECT: begin
                    if (sel_ok) begin
                        requested_floor <= sel_tgt;
                        if (sel_tgt > current_floor) dir_up <= 1'b1;
                        else if (sel_tgt < current_floor) dir_up <= 1'b0;
                    end
                    state <= S_TRAVEL;
                end
                S_TRAVEL: begin
                    if (serve) begin
                        door_open <= 1'b1;
                        cnt       <= '0;
                        state     <= S_DWELL;
                    end else if (cur_ok) begin
                        if (dir_up && f_lo_gt && lo_gt < requested_floor)
                            requested_floor <= lo_gt;
                        else if (!dir_up && f_hi_lt
                                 && hi_lt > requested_floor)
                            requested_floor <= hi_lt;
                    end
                end
                S_DWELL: begin
                    if (req_cur) begin
                        cnt <= '0;
                    end else if (cnt == DWELL_COUNT - 32'd1) begin
                        door_open <= 1'b0;
                        state     <= (|pending) ? S_SELECT : S_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler.
// Car position and idle are driven by hand, step by step.
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] btn = '0;
    logic [3:0] cur = '0;
    logic       idle = 1'b1;
    logic [3:0] req_f;
    logic [9:0] pend;
    logic       door;
    logic       dup;

    int n_chk = 0;
    int n_fail = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS (10),
        .FLOOR_W    (4),
        .DWELL_COUNT(32'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .call_btn       (btn),
        .current_floor  (cur),
        .car_idle       (idle),
        .requested_floor(req_f),
        .pending        (pend),
        .door_open      (door),
        .dir_up         (dup)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_req", 32'(req_f), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_door", 32'(door), 0);
        chk("rst_dir", 32'(dup), 1);
        rst = 1'b0;
        tick(1);

        // single call to floor 3, button held throughout
        btn[3] = 1'b1;
        tick(2);
        chk("p3_early", 32'(pend), 0);
        tick(1);
        chk("p3_set", 32'(pend), 32'h008);
        tick(1);
        chk("req_early", 32'(req_f), 0);
        tick(1);
        chk("req_3", 32'(req_f), 3);
        chk("dir_3", 32'(dup), 1);
        idle = 1'b0;
        cur = 4'd1;
        tick(1);
        cur = 4'd2;
        tick(1);
        cur = 4'd3;
        tick(1);
        chk("no_exit_busy", 32'(door), 0);
        idle = 1'b1;
        tick(1);
        chk("door_3", 32'(door), 1);
        chk("p3_clr", 32'(pend), 0);
        tick(3);
        chk("door_3_hold", 32'(door), 1);
        tick(1);
        chk("door_3_drop", 32'(door), 0);
        cur = 4'd5;
        tick(1);
        chk("wait_track", 32'(req_f), 5);
        chk("held_once", 32'(pend), 0);
        btn = '0;

        // SCAN order from floor 4 going up: 6, 7, then 2
        cur = 4'd4;
        btn = 10'h0C4;
        tick(3);
        chk("scan_pend", 32'(pend), 32'h0C4);
        btn = '0;
        tick(2);
        chk("scan_t6", 32'(req_f), 6);
        chk("scan_d6", 32'(dup), 1);
        idle = 1'b0;
        cur = 4'd5;
        tick(1);
        cur = 4'd6;
        idle = 1'b1;
        tick(1);
        chk("scan_door6", 32'(door), 1);
        chk("scan_p6", 32'(pend), 32'h084);
        tick(4);
        chk("scan_drop6", 32'(door), 0);
        tick(1);
        chk("scan_t7", 32'(req_f), 7);
        chk("scan_d7", 32'(dup), 1);
        cur = 4'd7;
        tick(1);
        chk("scan_p7", 32'(pend), 32'h004);
        tick(5);
        chk("scan_t2", 32'(req_f), 2);
        chk("scan_d2", 32'(dup), 0);
        idle = 1'b0;
        cur = 4'd5;
        tick(1);
        cur = 4'd2;
        idle = 1'b1;
        tick(1);
        chk("scan_door2", 32'(door), 1);
        chk("scan_p2", 32'(pend), 0);
        tick(4);

        // retarget from 8 to 5 while passing floor 3
        cur = 4'd1;
        tick(1);
        btn[8] = 1'b1;
        tick(3);
        btn = '0;
        tick(2);
        chk("rt_t8", 32'(req_f), 8);
        chk("rt_d8", 32'(dup), 1);
        idle = 1'b0;
        cur = 4'd2;
        tick(1);
        cur = 4'd3;
        btn[5] = 1'b1;
        tick(3);
        chk("rt_pend", 32'(pend), 32'h120);
        chk("rt_hold8", 32'(req_f), 8);
        tick(1);
        chk("rt_t5", 32'(req_f), 5);
        btn = '0;
        cur = 4'd4;
        tick(1);
        cur = 4'd5;
        idle = 1'b1;
        tick(1);
        chk("rt_door5", 32'(door), 1);
        chk("rt_p5", 32'(pend), 32'h100);
        tick(5);
        chk("rt_back8", 32'(req_f), 8);
        idle = 1'b0;
        cur = 4'd8;
        tick(1);
        idle = 1'b1;
        tick(1);
        chk("rt_door8", 32'(door), 1);

        // press for the current floor during dwell restarts it
        btn[8] = 1'b1;
        tick(4);
        chk("rs_door", 32'(door), 1);
        chk("rs_pend", 32'(pend), 0);
        tick(2);
        chk("rs_hold", 32'(door), 1);
        tick(1);
        chk("rs_drop", 32'(door), 0);

        // press landing on the dwell-entry clear is discarded
        btn = 10'h001;
        tick(3);
        chk("sc_pend", 32'(pend), 32'h001);
        btn = '0;
        tick(2);
        chk("sc_t0", 32'(req_f), 0);
        chk("sc_d0", 32'(dup), 0);
        idle = 1'b0;
        cur = 4'd0;
        tick(1);
        btn[0] = 1'b1;
        tick(2);
        idle = 1'b1;
        tick(1);
        chk("sc_door", 32'(door), 1);
        chk("sc_clr", 32'(pend), 0);
        tick(1);
        chk("sc_stay", 32'(pend), 0);
        btn = '0;
        tick(5);

        // go up to 9 so the direction is up again
        btn[9] = 1'b1;
        tick(3);
        btn = '0;
        tick(2);
        chk("up_t9", 32'(req_f), 9);
        chk("up_d9", 32'(dup), 1);
        idle = 1'b0;
        cur = 4'd9;
        tick(1);
        idle = 1'b1;
        tick(1);
        chk("up_door9", 32'(door), 1);
        tick(5);

        // boundary: calls at 0 and 9 with the car at 9 going up
        btn = 10'h201;
        tick(3);
        chk("bd_pend", 32'(pend), 32'h201);
        btn = '0;
        tick(2);
        chk("bd_t9", 32'(req_f), 9);
        chk("bd_d9", 32'(dup), 1);
        tick(1);
        chk("bd_door9", 32'(door), 1);
        chk("bd_p9", 32'(pend), 32'h001);
        tick(5);
        chk("bd_t0", 32'(req_f), 0);
        chk("bd_d0", 32'(dup), 0);
        cur = 4'd0;
        tick(1);
        chk("bd_door0", 32'(door), 1);
        tick(5);

        // asynchronous reset in the middle of travel
        btn = 10'h024;
        tick(3);
        btn = '0;
        tick(2);
        idle = 1'b0;
        cur = 4'd1;
        tick(1);
        chk("ar_pend", 32'(pend), 32'h024);
        chk("ar_req", 32'(req_f), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req0", 32'(req_f), 0);
        chk("ar_pend0", 32'(pend), 0);
        chk("ar_door0", 32'(door), 0);
        chk("ar_dir1", 32'(dup), 1);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("ar_after", 32'(pend), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Upstream stage of the elevator state machine: latches raw floor call buttons into a pending-request set and picks the next target floor with a SCAN policy (keep direction while requests remain ahead, then reverse). It drives `requested_floor` into the elevator state machine and consumes that block's `current_floor` and idle indication. It also times a door-open dwell at each served floor.

## Interface
- `NUM_FLOORS`, 10: number of floors and call buttons. Legal range is 2..16.
- `FLOOR_W`, 4: floor index width.
- `DWELL_COUNT`, 32'd20000000: door-open dwell length in clk cycles. Must be ≥ 1.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `call_btn` in NUM_FLOORS: raw call buttons, asynchronous to clk. Bit i is floor i.
- `current_floor` in FLOOR_W: car position from the state machine.
- `car_idle` in 1: high when the state machine is in its idle state.
- `requested_floor` out FLOOR_W: target floor, registered.
- `pending` out NUM_FLOORS: outstanding requests, registered.
- `door_open` out 1: high during dwell, registered.
- `dir_up` out 1: current SCAN direction, registered. 1 = up.

## Operation
- **Input capture.** Each `call_btn` bit passes through a 2-flop synchronizer, then a rising-edge detector, which produces a 1-cycle `req[i]` pulse. A held button produces one request only.
- **Pending set.** `pending[i]` is set by `req[i]` and cleared only by service (see DWELL). Requests arriving while a bit is already set are absorbed.
- **FSM states.** WAIT, SELECT, TRAVEL, DWELL. Reset state is WAIT.
- **WAIT.**
  - `requested_floor` holds `current_floor`.
  - If `pending` ≠ 0, go to SELECT on the next cycle.
- **SELECT** (exactly 1 cycle).
  - If `dir_up`: target = lowest pending floor ≥ `current_floor`. If none exists, target = highest pending floor below it.
  - If `!dir_up`: the mirror of the above.
  - Register the target into `requested_floor`.
  - Set `dir_up` = 1 if target > `current_floor`, 0 if target < `current_floor`; unchanged if equal.
  - Go to TRAVEL.
- **TRAVEL.**
  - Retarget: if a pending floor p lies strictly beyond `current_floor` in the `dir_up` direction and strictly nearer than `requested_floor`, set `requested_floor` to p. The nearest such p is taken.
  - Exit when `car_idle` = 1 and `current_floor` == `requested_floor`. On exit, go to DWELL, clear `pending[current_floor]`, set `door_open`, and clear the dwell counter.
- **DWELL.**
  - Counter runs 0..DWELL_COUNT-1. Then `door_open` drops and the FSM goes to SELECT if `pending` ≠ 0, else to WAIT.
  - A `req` for the current floor during DWELL restarts the counter and does not set `pending`.
- **Out-of-range input.** Floor indices ≥ NUM_FLOORS on `current_floor` are never matched. The scheduler stays in TRAVEL until the input is back in range.

## Timing
- **Reset values** (applied asynchronously): `requested_floor` = 0, `pending` = 0, `door_open` = 0, `dir_up` = 1. The FSM enters WAIT and the synchronizers and counter clear.
- **Button edge to pending bit:** 3 cycles (2 synchronizer stages plus 1 edge/latch stage).
- **Pending set to new target:** from WAIT, `pending` ≠ 0 takes 1 cycle to reach SELECT, and `requested_floor` updates at the end of SELECT, for 2 cycles total. End-to-end, button edge to `requested_floor` is 5 cycles.
- **Retarget latency:** 1 cycle from the pending bit being visible.
- **Dwell length:** `door_open` is high for exactly DWELL_COUNT cycles, starting the cycle after the TRAVEL exit condition is sampled.
- **Simultaneous set and clear:** a `req[i]` in the same cycle as the DWELL-entry clear of bit i is discarded, because that stop serves it.
- **Reset mid-TRAVEL:** outputs return to reset values immediately. `requested_floor` = 0 steers the car to floor 0 if the state machine is not also reset.

## Test plan
- **Reset.** Assert `rst` mid-TRAVEL with `pending` = 10'b0000100100. Required: all outputs go to reset values asynchronously, without waiting for a clk edge.
- **Single call.** Car idle at floor 0, pulse `call_btn[3]`. Required: `pending[3]` set at +3 cycles, `requested_floor` = 3 at +5 cycles, `dir_up` = 1. After the model reports floor 3 idle: `door_open` high for DWELL_COUNT = 4 cycles, `pending[3]` cleared, FSM back in WAIT.
- **SCAN order.** Car at floor 4 with `dir_up` = 1; calls at 2, 7, 6. Required: floors served in the order 6, 7, 2, with `dir_up` = 0 after 7.
- **Retarget.** In TRAVEL to floor 8 from floor 1, call floor 5 while `current_floor` = 3. Required: `requested_floor` = 5 one cycle after `pending[5]` is set. Floor 8 is served after the dwell at 5.
- **Edge cases.**
  - Held button gives a single request.
  - Press for the current floor during DWELL restarts the dwell and leaves `pending` = 0.
  - Press coinciding with the DWELL-entry clear leaves `pending[i]` = 0.
- **Wrap/boundary.** Calls only at floor 0 and floor 9 with the car at 9 and `dir_up` = 1. Required: 9 is served first (target equals the current floor), then the direction reverses to floor 0.
